mem_arbiter: RTL and testbench

//  Two-master front end for io_ctrl. Merges ACE core instruction-fetch (read-only) and data (R/W) ports

---
 rtl/ace_mem_pkg.sv | 14 +
 rtl/mem_timeout_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_mem_pkg.sv
// Shared constants for the ACE core memory front end: FSM state codes, master ids, error word, MMIO base.
package ace_mem_pkg;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_BUSY = 2'd1;
  localparam logic [1:0]  S_RESP = 2'd2;

  localparam logic        M_IF = 1'b0;
  localparam logic        M_D  = 1'b1;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] MMIO_BASE        = 32'h0010_0000;

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle timer: clear/enable up-counter that saturates and flags its terminal count (LIMIT-1).
module mem_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of io_ctrl: one transfer at a time, misalign reject, timeout.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority over fetch.
module mem_arbiter
  import ace_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_read_data
);

  logic [1:0]  state;
  logic        rd_q, wr_q, grant_q;
  logic        tmo_tc;

  logic        req_d, any_req, pick_d, win, win_wr, misaligned;
  logic [31:0] win_addr;
  logic        fin, fin_err, fin_ld, fin_m;
  logic [31:0] fin_data;

  assign mem_read  = rd_q & (state == S_BUSY) & ~mem_ack;
  assign mem_write = wr_q & (state == S_BUSY) & ~mem_ack;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= M_IF;
    end else if (state == S_IDLE && any_req) begin
      last_q <= win;
    end
  end
`endif

  always_comb begin
    req_d   = d_read | d_write;
    any_req = if_read | req_d;
`ifdef MEM_ARB_RR_EN
    pick_d  = req_d & (~if_read | (last_q == M_IF));
`else
    pick_d  = req_d;
`endif
    win        = pick_d ? M_D : M_IF;
    win_addr   = pick_d ? d_addr : if_addr;
    win_wr     = pick_d & d_write;
    misaligned = |win_addr[1:0];
  end

  // Single completion path shared by misalign reject, normal ack and timeout.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_ld   = 1'b0;
    fin_data = ERR_WORD;
    fin_m    = grant_q;
    case (state)
      S_IDLE: begin
        if (any_req && misaligned) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_ld  = 1'b1;
          fin_m   = win;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          fin      = 1'b1;
          fin_ld   = rd_q;
          fin_data = mem_read_data;
        end else if (tmo_tc) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_ld  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      grant_q        <= M_IF;
      mem_addr       <= '0;
      mem_write_data <= '0;
      if_ack         <= 1'b0;
      if_err         <= 1'b0;
      if_rdata       <= '0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      d_rdata        <= '0;
    end else begin
      if_ack <= fin && (fin_m == M_IF);
      if_err <= fin && (fin_m == M_IF) && fin_err;
      d_ack  <= fin && (fin_m == M_D);
      d_err  <= fin && (fin_m == M_D) && fin_err;
      if (fin && fin_ld) begin
        if (fin_m == M_D) d_rdata  <= fin_data;
        else              if_rdata <= fin_data;
      end
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_q <= win;
            rd_q    <= ~win_wr;
            wr_q    <= win_wr;
            if (misaligned) begin
              state <= S_RESP;
            end else begin
              state    <= S_BUSY;
              mem_addr <= win_addr;
              if (win_wr) mem_write_data <= d_wdata;
            end
          end
        end
        S_BUSY: begin
          if (fin) state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state != S_BUSY),
    .en    (state == S_BUSY),
    .tc    (tmo_tc)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model, per-cycle compare, directed scenarios.
module tb_mem_arbiter;

  localparam int unsigned TO   = 16;
  localparam logic [31:0] EW   = 32'hDEADBEEF;
  localparam int          MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_read, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_read_data = '0;

  mem_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .ERR_WORD       (EW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_read        (if_read),
    .if_addr        (if_addr),
    .if_ack         (if_ack),
    .if_rdata       (if_rdata),
    .if_err         (if_err),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_ack        (mem_ack),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // io_ctrl stand-in: acks in the io_lat-th cycle of a request; io_lat==0 never acks.
  int          io_lat = 3;
  logic [31:0] io_data = '0;
  int          stray_req = 0;
  int          stray_done = 0;
  int          run = 0;

  always @(posedge clk) begin
    if (reset) begin
      mem_ack <= 1'b0;
      run = 0;
    end else if (stray_req != stray_done) begin
      mem_ack <= 1'b1;
      stray_done = stray_req;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      run = 0;
    end else if ((mem_read || mem_write) && io_lat >= 2) begin
      if (run + 1 == io_lat - 1) begin
        mem_ack       <= 1'b1;
        mem_read_data <= io_data;
      end
      run = run + 1;
    end else begin
      run = 0;
    end
  end

  // Expected outputs per clock interval; interval n begins at rising edge n.
  typedef struct {
    bit          ia;
    bit          da;
    bit          rd;
    bit          wr;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  exp_t        ex [MAXC];
  int          cyc = 0;
  int          free_edge = 0;
  bit          m_last = 1'b0;   // 0 = fetch granted last, 1 = data
  logic [31:0] m_ird = '0;
  logic [31:0] m_drd = '0;

  always @(posedge clk) begin
    int          n, r, busy;
    bit          take_d, wr, err;
    logic [31:0] a, val;
    n   = cyc + 1;
    cyc = n;
    if (reset) begin
      for (int k = n; k < MAXC; k++) ex[k] = '{default: '0};
      free_edge = n + 1;
      m_last    = 1'b0;
      m_ird     = '0;
      m_drd     = '0;
    end else if (n >= free_edge && (if_read || d_read || d_write)) begin
      if ((d_read || d_write) && if_read) begin
`ifdef MEM_ARB_RR_EN
        take_d = (m_last == 1'b0);
`else
        take_d = 1'b1;
`endif
      end else begin
        take_d = d_read || d_write;
      end
      m_last = take_d;
      a  = take_d ? d_addr : if_addr;
      wr = take_d && d_write;
      if (a[1:0] != 2'b00) begin
        r   = n;
        err = 1'b1;
        val = EW;
      end else begin
        busy = (io_lat == 0) ? TO : io_lat;
        for (int k = n; k < n + busy; k++) begin
          if (!(io_lat != 0 && k == n + busy - 1) && k < MAXC) begin
            ex[k].rd    = !wr;
            ex[k].wr    = wr;
            ex[k].addr  = a;
            ex[k].wdata = d_wdata;
          end
        end
        r   = n + busy;
        err = (io_lat == 0);
        if (err)     val = EW;
        else if (wr) val = m_drd;
        else         val = io_data;
      end
      if (take_d) m_drd = val;
      else        m_ird = val;
      if (r < MAXC) begin
        ex[r].ia   = !take_d;
        ex[r].da   = take_d;
        ex[r].err  = err;
        ex[r].data = val;
      end
      free_edge = r + 2;
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (mem_read)        rd_cnt++;
    if (mem_write)       wr_cnt++;
    if (if_ack || d_ack) ack_cnt++;
    if (c < MAXC) begin
      chk("if_ack", 32'(if_ack), 32'(ex[c].ia));
      chk("d_ack", 32'(d_ack), 32'(ex[c].da));
      if (ex[c].ia) begin
        chk("if_rdata", if_rdata, ex[c].data);
        chk("if_err", 32'(if_err), 32'(ex[c].err));
      end
      if (ex[c].da) begin
        chk("d_rdata", d_rdata, ex[c].data);
        chk("d_err", 32'(d_err), 32'(ex[c].err));
      end
      chk("mem_read", 32'(mem_read), 32'(ex[c].rd));
      chk("mem_write", 32'(mem_write), 32'(ex[c].wr));
      if (ex[c].rd || ex[c].wr) chk("mem_addr", mem_addr, ex[c].addr);
      if (ex[c].wr)             chk("mem_write_data", mem_write_data, ex[c].wdata);
    end
  end

  task automatic wait_ack(input bit is_d, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack within bound", 32'(got), 32'd1);
  endtask

  task automatic wait_any(output bit who);
    bit got;
    got = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        got = 1'b1;
        who = d_ack;
        break;
      end
    end
    chk("any ack within bound", 32'(got), 32'd1);
  endtask

  task automatic issue_d(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit got;
    @(negedge clk);
    d_addr  = a;
    d_wdata = wd;
    d_read  = !wr;
    d_write = wr;
    wait_ack(1'b1, got);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic issue_if(input logic [31:0] a);
    bit got;
    @(negedge clk);
    if_addr = a;
    if_read = 1'b1;
    wait_ack(1'b0, got);
    if_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, abase;
    bit who;
    if_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0;   d_addr = '0;   d_wdata = '0;

    repeat (2) @(negedge clk);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_write_data", mem_write_data, 32'h0);
    reset = 1'b0;

    // aligned read, four-cycle io_ctrl
    io_lat = 4; io_data = 32'h12345678; base = rd_cnt;
    issue_d(1'b0, 32'h0000_0010, '0);
    chk("t1 d_rdata", d_rdata, 32'h12345678);
    chk("t1 d_err", 32'(d_err), 32'd0);
    @(negedge clk);
    chk("t1 mem_read cycles", 32'(rd_cnt - base), 32'd3);

    // write to MMIO range
    io_lat = 2; base = wr_cnt;
    issue_d(1'b1, 32'h0010_0008, 32'h0000_01FF);
    chk("t2 d_err", 32'(d_err), 32'd0);
    chk("t2 d_rdata held", d_rdata, 32'h12345678);
    @(negedge clk);
    chk("t2 mem_write_data", mem_write_data, 32'h0000_01FF);
    chk("t2 mem_write cycles", 32'(wr_cnt - base), 32'd1);

    // simultaneous requests
    io_lat = 3; io_data = 32'hA5A5_0001;
    @(negedge clk);
    if_addr = 32'h100; d_addr = 32'h200; if_read = 1'b1; d_read = 1'b1;
    wait_any(who);
    chk("t3 first grant data", 32'(who), 32'd1);
    d_read = 1'b0;
    wait_any(who);
    chk("t3 second grant fetch", 32'(who), 32'd0);
    if_read = 1'b0;
    @(negedge clk);
    if_read = 1'b1; d_read = 1'b1;
    wait_any(who);
    chk("t3 repeat tie first", 32'(who), 32'd1);
    wait_any(who);
`ifdef MEM_ARB_RR_EN
    chk("t3 repeat tie second", 32'(who), 32'd0);
`else
    chk("t3 repeat tie second", 32'(who), 32'd1);
`endif
    if (who) d_read = 1'b0;
    else     if_read = 1'b0;
    wait_any(who);
    if_read = 1'b0; d_read = 1'b0;

    // misaligned address never reaches io_ctrl
    base = rd_cnt;
    issue_d(1'b0, 32'h0000_0006, '0);
    chk("t4 d_err", 32'(d_err), 32'd1);
    chk("t4 d_rdata", d_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4 mem_read cycles", 32'(rd_cnt - base), 32'd0);

    // hung io_ctrl, then a stray ack
    io_lat = 0; base = rd_cnt;
    issue_d(1'b0, 32'h0000_0020, '0);
    chk("t5 d_err", 32'(d_err), 32'd1);
    chk("t5 d_rdata", d_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t5 mem_read cycles", 32'(rd_cnt - base), 32'(TO));
    abase = ack_cnt;
    stray_req++;
    repeat (4) @(negedge clk);
    chk("t5 stray ack ignored", 32'(ack_cnt - abase), 32'd0);

    // reset during BUSY
    @(negedge clk);
    d_addr = 32'h30; d_read = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6 mem_read async", 32'(mem_read), 32'd0);
    chk("t6 d_ack", 32'(d_ack), 32'd0);
    d_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    io_lat = 3; io_data = 32'hCAFE_0040;
    issue_if(32'h0000_0040);
    chk("t6 if_rdata", if_rdata, 32'hCAFE_0040);
    chk("t6 if_err", 32'(if_err), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
